// File: rtl/multiplier_pkg.sv
// Shared types and default parameters for the multiplier requester slice.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_DONE    = 2'd1,
    WAIT_RELEASE = 2'd2,
    RESULT       = 2'd3
  } requester_state_t;

endpackage

// File: rtl/requester_timer.sv
// Loadable down-counter bounding how long the requester waits for mul_ready.
module requester_timer
  import multiplier_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic decrement,
  output logic zero
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Count register: load wins over decrement, saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= LOAD_VALUE;
    end else if (decrement && !zero) begin
      count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CW{1'b0}});

endmodule

// File: rtl/multiplier_requester.sv
// Initiator side of the multiplier start/ready handshake: request port in,
// level-held start to the multiplier, captured product out on a response port.
module multiplier_requester
  import multiplier_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_timeout,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] mul_product
);

  requester_state_t   state_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [2*WIDTH-1:0] product_r;
  logic               timeout_r;
  logic               req_ready_s;
  logic               timer_load_s;
  logic               timer_dec_s;
  logic               timer_zero_s;

  // Acceptance is gated by a stale mul_ready left over from an earlier start.
  always_comb begin
    req_ready_s = 1'b0;
    if (state_r == IDLE) begin
      req_ready_s = !mul_ready;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign timer_load_s = (state_r == IDLE) && req_valid && req_ready_s;
  assign timer_dec_s  = (state_r == WAIT_DONE) && !mul_ready && !timer_zero_s;

  requester_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load_s),
    .decrement (timer_dec_s),
    .zero      (timer_zero_s)
  );

  // Handshake sequencer with operand and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      op_a_r    <= {WIDTH{1'b0}};
      op_b_r    <= {WIDTH{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_s) begin
            op_a_r  <= req_a;
            op_b_r  <= req_b;
            state_r <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A ready arriving on the last timer cycle still counts as success.
          if (mul_ready) begin
            product_r <= mul_product;
            timeout_r <= 1'b0;
            state_r   <= WAIT_RELEASE;
          end else if (timer_zero_s) begin
            product_r <= {(2*WIDTH){1'b0}};
            timeout_r <= 1'b1;
            state_r   <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!mul_ready) begin
            state_r <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_s;
  assign mul_start   = (state_r == WAIT_DONE);
  assign mul_a       = op_a_r;
  assign mul_b       = op_b_r;
  assign res_valid   = (state_r == RESULT);
  assign res_product = product_r;
  assign res_timeout = timeout_r;

endmodule

// File: tb/tb_multiplier_requester.sv
// Scoreboard bench for multiplier_requester with a variable-latency multiplier model.
module tb_multiplier_requester;

  localparam int W  = 8;
  localparam int TO = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic           res_ready = 1'b0;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic           req_ready, res_valid, res_timeout, mul_start, mul_ready;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] res_product, mul_product;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   lat = 9;
  int   cnt = 0;
  logic force_ready = 1'b0;
  logic model_ready;
  logic [2*W:0] sb_q[$];

  multiplier_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_product(res_product), .res_timeout(res_timeout),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier model: ready 'lat' cycles after start, dropped as soon as start falls.
  always @(posedge clock) cnt <= mul_start ? cnt + 1 : 0;
  assign model_ready = mul_start && (lat > 0) && (cnt >= lat);
  assign mul_ready   = force_ready || model_ready;
  assign mul_product = model_ready ? (2*W)'(mul_a) * (2*W)'(mul_b) : 16'hDEAD;

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic exp_to,
                      input int budget, output bit ok, output int acc);
    ok = 1'b0;
    acc = 0;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (req_ready === 1'b1) begin
        sb_q.push_back({exp_to, exp_to ? {(2*W){1'b0}} : (2*W)'(a) * (2*W)'(b)});
        ok = 1'b1;
      end
      @(posedge clock);
      #1;
      acc = cyc;
      @(negedge clock);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit found, output int seen);
    found = 1'b0;
    seen = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (res_valid === 1'b1) begin
        found = 1'b1;
        seen = cyc;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  task automatic pop_exp(output logic [2*W:0] e);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else e = {(2*W+1){1'b1}};
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++;
    if ({res_valid, mul_start, res_timeout, req_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got v/s/t/r=%b%b%b%b expected 0001", res_valid, mul_start, res_timeout, req_ready);
    end
    vectors++;
    if (res_product !== 16'd0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data: got prod=%0d a=%0d b=%0d expected 0 0 0", res_product, mul_a, mul_b);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_normal();
    bit ok, found;
    int acc, seen;
    logic [2*W:0] e;
    lat = 9;
    send(8'd13, 8'd11, 1'b0, 5, ok, acc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL normal_accept: got not accepted expected accepted"); end
    vectors++;
    if (mul_a !== 8'd13 || mul_b !== 8'd11) begin
      miscompares++;
      $display("FAIL normal_operands: got %0d,%0d expected 13,11", mul_a, mul_b);
    end
    for (int k = 0; k < 11; k++) begin
      vectors++;
      if (mul_start !== 1'(k < 10)) begin
        miscompares++;
        $display("FAIL normal_start: cycle %0d got %b expected %b", k, mul_start, 1'(k < 10));
      end
      @(negedge clock);
    end
    wait_valid(5, found, seen);
    vectors++;
    if (!found || seen - acc != 11) begin
      miscompares++;
      $display("FAIL normal_latency: got found=%b lat=%0d expected 1 11", found, seen - acc);
    end
    pop_exp(e);
    vectors++;
    if (res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
      miscompares++;
      $display("FAIL normal_result: got %0d/%b expected %0d/%b", res_product, res_timeout, e[2*W-1:0], e[2*W]);
    end
    consume();
    vectors++;
    if (res_valid !== 1'b0) begin miscompares++; $display("FAIL normal_consume: got res_valid=%b expected 0", res_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok, found, got, ready_seen;
    int acc, seen;
    logic [2*W:0] e;
    lat = 9;
    res_ready = 1'b1;
    got = 1'b0;
    ready_seen = 1'b0;
    send(8'd255, 8'd255, 1'b0, 5, ok, acc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_accept1: got not accepted expected accepted"); end
    for (int i = 0; i < 40 && !ready_seen; i++) begin
      #1;
      if (res_valid === 1'b1 && !got) begin
        got = 1'b1;
        pop_exp(e);
        vectors++;
        if (res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
          miscompares++;
          $display("FAIL b2b_result1: got %0d/%b expected %0d/%b", res_product, res_timeout, e[2*W-1:0], e[2*W]);
        end
      end
      if (req_ready === 1'b1) begin
        ready_seen = 1'b1;
        vectors++;
        if (!got || res_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready_early: got req_ready with result_seen=%b res_valid=%b expected 1 0", got, res_valid);
        end
      end
      @(posedge clock);
      @(negedge clock);
    end
    vectors++;
    if (!ready_seen || !got) begin
      miscompares++;
      $display("FAIL b2b_progress: got ready=%b result=%b expected 1 1", ready_seen, got);
    end
    send(8'd0, 8'd7, 1'b0, 5, ok, acc);
    wait_valid(20, found, seen);
    pop_exp(e);
    vectors++;
    if (!found || res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
      miscompares++;
      $display("FAIL b2b_result2: got found=%b %0d/%b expected 1 %0d/%b", found, res_product, res_timeout, e[2*W-1:0], e[2*W]);
    end
    @(negedge clock);
    vectors++;
    if (res_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_consumed: got res_valid=%b expected 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, found;
    int acc, seen;
    logic [2*W:0] e;
    lat = 9;
    send(8'd6, 8'd7, 1'b0, 5, ok, acc);
    wait_valid(20, found, seen);
    vectors++;
    if (!found) begin miscompares++; $display("FAIL bp_valid: got no res_valid expected res_valid"); end
    pop_exp(e);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (res_valid !== 1'b1 || res_product !== e[2*W-1:0] || res_timeout !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got v=%b p=%0d t=%b rr=%b expected 1 %0d 0 0",
                 i, res_valid, res_product, res_timeout, req_ready, e[2*W-1:0]);
      end
      @(negedge clock);
    end
    consume();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_single: got res_valid=%b expected 0", res_valid); end
      @(negedge clock);
    end
  endtask

  task automatic test_timeout();
    bit ok, found;
    int acc, seen;
    logic [2*W:0] e;
    lat = 0;
    send(8'd3, 8'd5, 1'b1, 5, ok, acc);
    wait_valid(90, found, seen);
    vectors++;
    if (!found || seen - acc != TO + 1) begin
      miscompares++;
      $display("FAIL to_latency: got found=%b lat=%0d expected 1 %0d", found, seen - acc, TO + 1);
    end
    pop_exp(e);
    vectors++;
    if (res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
      miscompares++;
      $display("FAIL to_result: got %0d/%b expected %0d/%b", res_product, res_timeout, e[2*W-1:0], e[2*W]);
    end
    consume();
    lat = TO - 1;
    send(8'd9, 8'd10, 1'b0, 5, ok, acc);
    wait_valid(90, found, seen);
    vectors++;
    if (!found || seen - acc != TO + 1) begin
      miscompares++;
      $display("FAIL coincide_latency: got found=%b lat=%0d expected 1 %0d", found, seen - acc, TO + 1);
    end
    pop_exp(e);
    vectors++;
    if (res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
      miscompares++;
      $display("FAIL coincide_result: got %0d/%b expected %0d/%b", res_product, res_timeout, e[2*W-1:0], e[2*W]);
    end
    consume();
  endtask

  task automatic test_stale_ready();
    bit ok, found;
    int acc, seen;
    logic [2*W:0] e;
    lat = 9;
    force_ready = 1'b1;
    req_a = 8'd2;
    req_b = 8'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (req_ready !== 1'b0 || mul_start !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_block: cycle %0d got req_ready=%b mul_start=%b expected 0 0", i, req_ready, mul_start);
      end
      @(posedge clock);
      @(negedge clock);
    end
    force_ready = 1'b0;
    send(8'd2, 8'd3, 1'b0, 2, ok, acc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stale_accept: got not accepted expected accepted"); end
    wait_valid(20, found, seen);
    pop_exp(e);
    vectors++;
    if (!found || res_product !== e[2*W-1:0] || res_timeout !== e[2*W]) begin
      miscompares++;
      $display("FAIL stale_result: got found=%b %0d/%b expected 1 %0d/%b", found, res_product, res_timeout, e[2*W-1:0], e[2*W]);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acc;
    lat = 9;
    send(8'd4, 8'd5, 1'b0, 5, ok, acc);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (mul_start !== 1'b0 || res_valid !== 1'b0 || mul_a !== 8'd0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got start=%b valid=%b a=%0d rr=%b expected 0 0 0 1", mul_start, res_valid, mul_a, req_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (res_valid !== 1'b0 || mul_start !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_drop: cycle %0d got valid=%b start=%b expected 0 0", i, res_valid, mul_start);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    test_reset();
    test_normal();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_stale_ready();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
